tlb_l1: RTL

TLB_L1 -- requirements
Module: tlb_l1

---
 rtl/tlb_l1_pkg.sv | 30 +++
 rtl/tlb_l1.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/tlb_l1_pkg.sv
// rtl/tlb_l1_pkg.sv - shared types and constants for the L1 TLB
package tlb_l1_pkg;

  localparam int TLB_ENTRIES = 8;
  localparam int IDX_W       = 3;
  localparam int VPN_W       = 27;
  localparam int PPN_W       = 44;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOOKUP    = 3'd1,
    ST_WALK_REQ  = 3'd2,
    ST_WALK_WAIT = 3'd3,
    ST_RESPOND   = 3'd4
  } tlb_state_t;

  typedef struct packed {
    logic             valid;
    logic [VPN_W-1:0] vpn;
    logic [PPN_W-1:0] ppn;
    logic             dirty;
    logic             exec;
  } tlb_entry_t;

  // A VA is canonical when bits 63..39 all replicate bit 38
  function automatic logic is_canonical(input logic [63:0] va);
    return (va[63:39] == {25{va[38]}});
  endfunction

endpackage

// File: rtl/tlb_l1.sv
// rtl/tlb_l1.sv - 8-entry fully associative L1 TLB with page-walk miss path
module tlb_l1
  import tlb_l1_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [63:0] req_va,
  input  logic        req_store,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [63:0] rsp_pa,
  output logic        rsp_fault,
  output logic        rsp_dirty,
  output logic        rsp_exec,
  input  logic        flush,
  output logic        walk_req,
  output logic [63:0] walk_va,
  input  logic        walk_rsp_valid,
  input  logic [63:0] walk_pa,
  input  logic        walk_fault,
  input  logic        walk_dirty,
  input  logic        walk_exec
);

  tlb_state_t        state_q;
  logic [63:0]       va_q;
  logic              store_q;
  logic              flush_pending_q;
  logic [IDX_W-1:0]  rr_q;
  tlb_entry_t        entries [TLB_ENTRIES];

  logic              hit;
  logic [IDX_W-1:0]  hit_idx;
  logic              any_free;
  logic [IDX_W-1:0]  free_idx;
  logic [IDX_W-1:0]  victim_idx;
  tlb_entry_t        fill_entry;
  logic              unused_walk_pa_bits;

  // Walker supplies a 4 KiB-granular PA; only bits 55..12 are stored
  assign unused_walk_pa_bits = ^{walk_pa[63:56], walk_pa[11:0]};

  assign req_ready = (state_q == ST_IDLE);

  // CAM match of the registered VA against every valid entry
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (entries[i].valid && (entries[i].vpn == va_q[38:12])) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  // Victim choice: lowest-index free slot, else the round-robin slot
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
      if (!entries[i].valid) begin
        any_free = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    victim_idx = any_free ? free_idx : rr_q;
  end

  // Entry image built from the walker result
  always_comb begin
    fill_entry       = '0;
    fill_entry.valid = 1'b1;
    fill_entry.vpn   = va_q[38:12];
    fill_entry.ppn   = walk_pa[55:12];
    fill_entry.dirty = walk_dirty;
    fill_entry.exec  = walk_exec;
  end

  // Control FSM, entry array and registered response/walk outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      va_q            <= '0;
      store_q         <= 1'b0;
      flush_pending_q <= 1'b0;
      rr_q            <= '0;
      rsp_valid       <= 1'b0;
      rsp_pa          <= '0;
      rsp_fault       <= 1'b0;
      rsp_dirty       <= 1'b0;
      rsp_exec        <= 1'b0;
      walk_req        <= 1'b0;
      walk_va         <= '0;
      for (int i = 0; i < TLB_ENTRIES; i++) begin
        entries[i].valid <= 1'b0;
      end
    end else begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      walk_req  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            va_q    <= req_va;
            store_q <= req_store;
            state_q <= ST_LOOKUP;
          end
        end

        ST_LOOKUP: begin
          if (!is_canonical(va_q)) begin
            rsp_valid <= 1'b1;
            rsp_fault <= 1'b1;
            rsp_pa    <= '0;
            rsp_dirty <= 1'b0;
            rsp_exec  <= 1'b0;
            state_q   <= ST_IDLE;
          end else if (hit && !(store_q && !entries[hit_idx].dirty)) begin
            rsp_valid <= 1'b1;
            rsp_pa    <= {8'd0, entries[hit_idx].ppn, va_q[11:0]};
            rsp_dirty <= entries[hit_idx].dirty;
            rsp_exec  <= entries[hit_idx].exec;
            state_q   <= ST_IDLE;
          end else begin
            // A store to a clean page must re-walk so the walker can set D
            if (hit) begin
              entries[hit_idx].valid <= 1'b0;
            end
            walk_req <= 1'b1;
            walk_va  <= va_q;
            state_q  <= ST_WALK_REQ;
          end
        end

        ST_WALK_REQ: begin
          if (flush) begin
            flush_pending_q <= 1'b1;
          end
          state_q <= ST_WALK_WAIT;
        end

        ST_WALK_WAIT: begin
          if (flush) begin
            flush_pending_q <= 1'b1;
          end
          if (walk_rsp_valid) begin
            if (!walk_fault && !flush_pending_q && !flush) begin
              entries[victim_idx] <= fill_entry;
              if (!any_free) begin
                rr_q <= rr_q + IDX_W'(1);
              end
            end
            rsp_valid <= 1'b1;
            rsp_fault <= walk_fault;
            rsp_pa    <= walk_fault ? 64'd0 : {8'd0, walk_pa[55:12], va_q[11:0]};
            rsp_dirty <= walk_dirty;
            rsp_exec  <= walk_exec;
            state_q   <= ST_RESPOND;
          end
        end

        ST_RESPOND: begin
          flush_pending_q <= 1'b0;
          state_q         <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Flush is applied last so it overrides any fill or hit in this cycle
      if (flush) begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
          entries[i].valid <= 1'b0;
        end
      end
    end
  end

endmodule
